// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: length-prefixed PT memory -> CT memory under a 24-bit key, external S memory.
// Latency: rdy is low for exactly 1796 + 9*L cycles after the edge that accepts en (L = pt[0]).
module arc4_encrypt #(
    parameter int KEY_BYTES = 3,
    parameter int MSG_MAX   = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             s_addr,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren
);
    localparam int CW = $clog2(MSG_MAX + 1);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0] KLAST = KW'(KEY_BYTES - 1);

    typedef enum logic [4:0] {
        IDLE, INIT,
        KSA_RDI, KSA_W1, KSA_RDJ, KSA_W2, KSA_WR1, KSA_WR2,
        LEN_RD, LEN_W, LEN_GET,
        P_RDI, P_W1, P_RDJ, P_W2, P_WR1, P_WR2, P_RDP, P_W3, P_XOR,
        DONE
    } state_t;

    state_t                 state_q;
    logic                   rdy_q;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [7:0]             i_q, j_q, si_q, sj_q;
    logic [CW-1:0]          k_q, len_q;
    logic [KW-1:0]          kidx_q;
    logic [7:0]             s_addr_q, s_wrdata_q, pt_addr_q, ct_addr_q, ct_wrdata_q;
    logic                   s_wren_q, ct_wren_q;

    logic [7:0] kbyte, i_inc, ksa_j, prga_j, pad_addr;

    always_comb begin
        kbyte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx_q == KW'(b)) kbyte = key_q[8*(KEY_BYTES-1-b) +: 8];
        end
        i_inc    = i_q + 8'd1;
        ksa_j    = j_q + s_rddata + kbyte;
        prga_j   = j_q + s_rddata;
        pad_addr = si_q + sj_q;
    end

    // Every S/PT read is issued two edges before its data is consumed (registered address + sync RAM).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b1;
            key_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            len_q       <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            kidx_q      <= '0;
            s_addr_q    <= '0;
            s_wrdata_q  <= '0;
            s_wren_q    <= 1'b0;
            pt_addr_q   <= '0;
            ct_addr_q   <= '0;
            ct_wrdata_q <= '0;
            ct_wren_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        key_q      <= key;
                        rdy_q      <= 1'b0;
                        s_addr_q   <= 8'd0;
                        s_wrdata_q <= 8'd0;
                        s_wren_q   <= 1'b1;
                        i_q        <= 8'd1;
                        state_q    <= INIT;
                    end
                end
                INIT: begin
                    if (i_q != 8'd0) begin
                        s_addr_q   <= i_q;
                        s_wrdata_q <= i_q;
                        i_q        <= i_inc;
                    end else begin
                        s_wren_q <= 1'b0;
                        j_q      <= 8'd0;
                        kidx_q   <= '0;
                        state_q  <= KSA_RDI;
                    end
                end
                KSA_RDI: begin
                    s_wren_q <= 1'b0;
                    s_addr_q <= i_q;
                    state_q  <= KSA_W1;
                end
                KSA_W1: state_q <= KSA_RDJ;
                KSA_RDJ: begin
                    si_q     <= s_rddata;
                    j_q      <= ksa_j;
                    s_addr_q <= ksa_j;
                    state_q  <= KSA_W2;
                end
                KSA_W2: state_q <= KSA_WR1;
                KSA_WR1: begin
                    sj_q       <= s_rddata;
                    s_addr_q   <= j_q;
                    s_wrdata_q <= si_q;
                    s_wren_q   <= 1'b1;
                    state_q    <= KSA_WR2;
                end
                KSA_WR2: begin
                    s_addr_q   <= i_q;
                    s_wrdata_q <= sj_q;
                    i_q        <= i_inc;
                    kidx_q     <= (kidx_q == KLAST) ? '0 : kidx_q + 1'b1;
                    state_q    <= (i_q == 8'hFF) ? LEN_RD : KSA_RDI;
                end
                LEN_RD: begin
                    s_wren_q  <= 1'b0;
                    pt_addr_q <= 8'd0;
                    state_q   <= LEN_W;
                end
                LEN_W: state_q <= LEN_GET;
                LEN_GET: begin
                    len_q       <= pt_rddata;
                    ct_addr_q   <= 8'd0;
                    ct_wrdata_q <= pt_rddata;
                    ct_wren_q   <= 1'b1;
                    i_q         <= 8'd0;
                    j_q         <= 8'd0;
                    k_q         <= CW'(1);
                    state_q     <= (pt_rddata == 8'd0) ? DONE : P_RDI;
                end
                P_RDI: begin
                    ct_wren_q <= 1'b0;
                    i_q       <= i_inc;
                    s_addr_q  <= i_inc;
                    state_q   <= P_W1;
                end
                P_W1: state_q <= P_RDJ;
                P_RDJ: begin
                    si_q     <= s_rddata;
                    j_q      <= prga_j;
                    s_addr_q <= prga_j;
                    state_q  <= P_W2;
                end
                P_W2: state_q <= P_WR1;
                P_WR1: begin
                    sj_q       <= s_rddata;
                    s_addr_q   <= j_q;
                    s_wrdata_q <= si_q;
                    s_wren_q   <= 1'b1;
                    state_q    <= P_WR2;
                end
                P_WR2: begin
                    s_addr_q   <= i_q;
                    s_wrdata_q <= sj_q;
                    state_q    <= P_RDP;
                end
                P_RDP: begin
                    s_wren_q  <= 1'b0;
                    s_addr_q  <= pad_addr;
                    pt_addr_q <= k_q;
                    state_q   <= P_W3;
                end
                P_W3: state_q <= P_XOR;
                P_XOR: begin
                    ct_addr_q   <= k_q;
                    ct_wrdata_q <= pt_rddata ^ s_rddata;
                    ct_wren_q   <= 1'b1;
                    // Compare before incrementing so L=255 exits without k wrapping.
                    if (k_q == len_q) begin
                        state_q <= DONE;
                    end else begin
                        k_q     <= k_q + CW'(1);
                        state_q <= P_RDI;
                    end
                end
                DONE: begin
                    ct_wren_q <= 1'b0;
                    rdy_q     <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdy       = rdy_q;
    assign s_addr    = s_addr_q;
    assign s_wrdata  = s_wrdata_q;
    assign s_wren    = s_wren_q;
    assign pt_addr   = pt_addr_q;
    assign ct_addr   = ct_addr_q;
    assign ct_wrdata = ct_wrdata_q;
    assign ct_wren   = ct_wren_q;
endmodule
